// File: rtl/sonic_pma_reset_seq.sv
// sonic_pma_reset_seq
// Transceiver PMA/PCS reset sequencer. One TX sequencer shared by every lane
// walks the PLL powerdown, PLL lock wait and TX settle phases. Each lane has
// its own RX sequencer that waits for calibration and a stable CDR data lock.
// All outputs are registered and decoded from the next state, so a state
// change shows up on the pins one clock after the input sample that caused it.
//
// Optional feature: define SONIC_PMA_RESET_LOSS_CNT_EN to add the
// lock_loss_cnt output. It holds one 8-bit saturating counter per lane that
// counts RX ready -> RX lock fall-backs and is cleared only by reset.

module sonic_pma_reset_seq #(
  parameter int NUM_LANES        = 4,
  parameter int PLL_PD_CYCLES    = 1000,
  parameter int TX_SETTLE_CYCLES = 64,
  parameter int RX_LOCK_CYCLES   = 500
) (
  input  logic                 phy_mgmt_clk,
  input  logic                 phy_mgmt_clk_reset_n,
  input  logic [NUM_LANES-1:0] pll_locked,
  input  logic [NUM_LANES-1:0] tx_cal_busy,
  input  logic [NUM_LANES-1:0] rx_cal_busy,
  input  logic [NUM_LANES-1:0] rx_is_lockedtodata,
  output logic [NUM_LANES-1:0] pll_powerdown,
  output logic [NUM_LANES-1:0] tx_analogreset,
  output logic [NUM_LANES-1:0] tx_digitalreset,
  output logic [NUM_LANES-1:0] tx_ready,
  output logic [NUM_LANES-1:0] rx_analogreset,
  output logic [NUM_LANES-1:0] rx_digitalreset,
  output logic [NUM_LANES-1:0] rx_ready
`ifdef SONIC_PMA_RESET_LOSS_CNT_EN
  ,
  output logic [8*NUM_LANES-1:0] lock_loss_cnt
`endif
);

  // Each counter is just wide enough to hold its terminal value.
  localparam int PD_W     = $clog2(PLL_PD_CYCLES + 1);
  localparam int SETTLE_W = $clog2(TX_SETTLE_CYCLES + 1);
  localparam int LOCK_W   = $clog2(RX_LOCK_CYCLES + 1);

  // A phase ends on the clock where the counter holds "cycles - 1". That
  // clock is the last one spent in the phase.
  localparam logic [PD_W-1:0]     PD_LAST     = PD_W'(PLL_PD_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(TX_SETTLE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(RX_LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    TX_PD     = 2'd0,
    TX_WAIT   = 2'd1,
    TX_SETTLE = 2'd2,
    TX_RDY    = 2'd3
  } txState_e;

  typedef enum logic [1:0] {
    RX_ANA  = 2'd0,
    RX_LOCK = 2'd1,
    RX_RDY  = 2'd2
  } rxState_e;

  txState_e              txState_q, txState_d;
  logic [PD_W-1:0]       pdCnt_q, pdCnt_d;
  logic [SETTLE_W-1:0]   settleCnt_q, settleCnt_d;

  rxState_e              rxState_q [NUM_LANES];
  rxState_e              rxState_d [NUM_LANES];
  logic [LOCK_W-1:0]     lockCnt_q [NUM_LANES];
  logic [LOCK_W-1:0]     lockCnt_d [NUM_LANES];

  logic [NUM_LANES-1:0]  pllPowerdown_q;
  logic [NUM_LANES-1:0]  txAnalogReset_q;
  logic [NUM_LANES-1:0]  txDigitalReset_q;
  logic [NUM_LANES-1:0]  txReady_q;
  logic [NUM_LANES-1:0]  rxAnalogReset_q;
  logic [NUM_LANES-1:0]  rxDigitalReset_q;
  logic [NUM_LANES-1:0]  rxReady_q;

  logic                  allPllLocked;
  logic                  anyTxCalBusy;

  assign allPllLocked = &pll_locked;
  assign anyTxCalBusy = |tx_cal_busy;

  // TX next state. Losing any PLL lock after the wait phase restarts the
  // whole powerdown sequence, and it does so before the settle count is checked.
  always_comb begin
    txState_d   = txState_q;
    pdCnt_d     = pdCnt_q;
    settleCnt_d = settleCnt_q;
    case (txState_q)
      TX_PD: begin
        if (pdCnt_q == PD_LAST) begin
          txState_d = TX_WAIT;
          pdCnt_d   = '0;
        end else begin
          pdCnt_d = pdCnt_q + PD_W'(1);
        end
      end
      TX_WAIT: begin
        if (allPllLocked && !anyTxCalBusy) begin
          txState_d   = TX_SETTLE;
          settleCnt_d = '0;
        end
      end
      TX_SETTLE: begin
        if (!allPllLocked) begin
          txState_d   = TX_PD;
          pdCnt_d     = '0;
          settleCnt_d = '0;
        end else if (settleCnt_q == SETTLE_LAST) begin
          txState_d   = TX_RDY;
          settleCnt_d = '0;
        end else begin
          settleCnt_d = settleCnt_q + SETTLE_W'(1);
        end
      end
      TX_RDY: begin
        if (!allPllLocked) begin
          txState_d   = TX_PD;
          pdCnt_d     = '0;
          settleCnt_d = '0;
        end
      end
      default: begin
        txState_d   = TX_PD;
        pdCnt_d     = '0;
        settleCnt_d = '0;
      end
    endcase
  end

  // TX state, counters and lane-replicated TX outputs decoded from next state.
  always_ff @(posedge phy_mgmt_clk) begin
    if (!phy_mgmt_clk_reset_n) begin
      txState_q        <= TX_PD;
      pdCnt_q          <= '0;
      settleCnt_q      <= '0;
      pllPowerdown_q   <= '1;
      txAnalogReset_q  <= '1;
      txDigitalReset_q <= '1;
      txReady_q        <= '0;
    end else begin
      txState_q        <= txState_d;
      pdCnt_q          <= pdCnt_d;
      settleCnt_q      <= settleCnt_d;
      pllPowerdown_q   <= {NUM_LANES{txState_d == TX_PD}};
      txAnalogReset_q  <= {NUM_LANES{(txState_d == TX_PD) || (txState_d == TX_WAIT)}};
      txDigitalReset_q <= {NUM_LANES{txState_d != TX_RDY}};
      txReady_q        <= {NUM_LANES{txState_d == TX_RDY}};
    end
  end

  // Per-lane RX next state. A TX restart wins over everything else. After
  // that, RX calibration wins over data lock.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rxState_d[i] = rxState_q[i];
      lockCnt_d[i] = lockCnt_q[i];
      if (txState_d == TX_PD) begin
        rxState_d[i] = RX_ANA;
        lockCnt_d[i] = '0;
      end else begin
        case (rxState_q[i])
          RX_ANA: begin
            if (!rx_cal_busy[i] && (txState_q != TX_PD)) begin
              rxState_d[i] = RX_LOCK;
              lockCnt_d[i] = '0;
            end
          end
          RX_LOCK: begin
            if (rx_cal_busy[i]) begin
              rxState_d[i] = RX_ANA;
              lockCnt_d[i] = '0;
            end else if (!rx_is_lockedtodata[i]) begin
              lockCnt_d[i] = '0;
            end else if (lockCnt_q[i] == LOCK_LAST) begin
              rxState_d[i] = RX_RDY;
              lockCnt_d[i] = '0;
            end else begin
              lockCnt_d[i] = lockCnt_q[i] + LOCK_W'(1);
            end
          end
          RX_RDY: begin
            if (rx_cal_busy[i]) begin
              rxState_d[i] = RX_ANA;
              lockCnt_d[i] = '0;
            end else if (!rx_is_lockedtodata[i]) begin
              rxState_d[i] = RX_LOCK;
              lockCnt_d[i] = '0;
            end
          end
          default: begin
            rxState_d[i] = RX_ANA;
            lockCnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Per-lane RX state, lock counters and RX outputs decoded from next state.
  always_ff @(posedge phy_mgmt_clk) begin
    if (!phy_mgmt_clk_reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rxState_q[i] <= RX_ANA;
        lockCnt_q[i] <= '0;
      end
      rxAnalogReset_q  <= '1;
      rxDigitalReset_q <= '1;
      rxReady_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rxState_q[i]        <= rxState_d[i];
        lockCnt_q[i]        <= lockCnt_d[i];
        rxAnalogReset_q[i]  <= (rxState_d[i] == RX_ANA);
        rxDigitalReset_q[i] <= (rxState_d[i] != RX_RDY);
        rxReady_q[i]        <= (rxState_d[i] == RX_RDY);
      end
    end
  end

`ifdef SONIC_PMA_RESET_LOSS_CNT_EN
  logic [7:0] lossCnt_q [NUM_LANES];

  // Count ready -> lock fall-backs per lane, holding at 255.
  always_ff @(posedge phy_mgmt_clk) begin
    if (!phy_mgmt_clk_reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lossCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if ((rxState_q[i] == RX_RDY) && (rxState_d[i] == RX_LOCK) &&
            (lossCnt_q[i] != 8'hFF)) begin
          lossCnt_q[i] <= lossCnt_q[i] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLossOut
    assign lock_loss_cnt[8*g +: 8] = lossCnt_q[g];
  end
`endif

  assign pll_powerdown   = pllPowerdown_q;
  assign tx_analogreset  = txAnalogReset_q;
  assign tx_digitalreset = txDigitalReset_q;
  assign tx_ready        = txReady_q;
  assign rx_analogreset  = rxAnalogReset_q;
  assign rx_digitalreset = rxDigitalReset_q;
  assign rx_ready        = rxReady_q;

endmodule

// File: doc/sonic_pma_reset_seq.md
SONIC_PMA_RESET_SEQ -- requirements
Module: sonic_pma_reset_seq

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of transceiver lanes (1..32).
REQ-002 SHALL have parameter PLL_PD_CYCLES, default 1000, pll_powerdown assertion time in clocks (>=1).
REQ-003 SHALL have parameter TX_SETTLE_CYCLES, default 64, delay from tx_analogreset release to tx_digitalreset release (>=1).
REQ-004 SHALL have parameter RX_LOCK_CYCLES, default 500, consecutive rx_is_lockedtodata-high clocks required before rx_digitalreset release (>=1).
REQ-005 SHALL have one clock and one synchronous active-low reset, ports as follows:
- phy_mgmt_clk  in  1  sole clock; all logic on rising edge
- phy_mgmt_clk_reset_n  in  1  synchronous active-low reset
- pll_locked  in  NUM_LANES  per-lane TX PLL lock
- tx_cal_busy  in  NUM_LANES  TX calibration in progress
- rx_cal_busy  in  NUM_LANES  RX calibration in progress
- rx_is_lockedtodata  in  NUM_LANES  CDR locked to data
- pll_powerdown  out  NUM_LANES  TX PLL powerdown
- tx_analogreset  out  NUM_LANES  TX PMA analog reset
- tx_digitalreset  out  NUM_LANES  TX PCS digital reset
- tx_ready  out  NUM_LANES  TX path ready
- rx_analogreset  out  NUM_LANES  RX analog reset
- rx_digitalreset  out  NUM_LANES  RX digital reset
- rx_ready  out  NUM_LANES  RX path ready
REQ-006 SHALL treat inputs as synchronous to phy_mgmt_clk; no internal synchronisers.

Function
REQ-007 TX FSM SHALL be shared by all lanes; states TX_PD, TX_WAIT, TX_SETTLE, TX_RDY; all TX outputs drive identical value on every lane.
REQ-008 TX_PD: pll_powerdown, tx_analogreset, tx_digitalreset all 1, tx_ready 0; counter runs; after exactly PLL_PD_CYCLES clocks in TX_PD -> TX_WAIT.
REQ-009 TX_WAIT: pll_powerdown 0, tx_analogreset/tx_digitalreset 1; -> TX_SETTLE when all pll_locked 1 and all tx_cal_busy 0 in same cycle.
REQ-010 TX_SETTLE: tx_analogreset 0, tx_digitalreset 1; after TX_SETTLE_CYCLES clocks -> TX_RDY.
REQ-011 TX_RDY: tx_digitalreset 0, tx_ready all 1.
REQ-012 In TX_SETTLE or TX_RDY, any pll_locked bit 0 SHALL force TX_PD next cycle (counter cleared, tx_ready 0 on next cycle).
REQ-013 Each lane SHALL have an independent RX FSM: states RX_ANA, RX_LOCK, RX_RDY.
REQ-014 RX_ANA: rx_analogreset 1, rx_digitalreset 1, rx_ready 0; -> RX_LOCK when that lane's rx_cal_busy 0 and TX FSM not in TX_PD.
REQ-015 RX_LOCK: rx_analogreset 0, rx_digitalreset 1; lock counter increments while rx_is_lockedtodata 1, clears to 0 when 0; on reaching RX_LOCK_CYCLES -> RX_RDY.
REQ-016 RX_RDY: rx_digitalreset 0, rx_ready 1; rx_is_lockedtodata 0 SHALL return lane to RX_LOCK next cycle with counter 0.
REQ-017 TX FSM entering TX_PD SHALL force every RX FSM to RX_ANA same cycle (takes priority over REQ-015/016).
REQ-018 rx_cal_busy 1 in RX_LOCK or RX_RDY SHALL return that lane to RX_ANA.
REQ-019 All outputs SHALL be registered; state change visible on outputs one clock after the triggering input edge sample.
REQ-020 Counters SHALL be $clog2(max+1) wide and saturate, never wrap.

Reset
REQ-021 With phy_mgmt_clk_reset_n 0 at a clock edge: TX FSM=TX_PD, RX FSMs=RX_ANA, all counters 0; pll_powerdown, tx/rx analog/digital reset all ones; tx_ready, rx_ready all zeros.
REQ-022 Reset asserted mid-sequence SHALL abort immediately to REQ-021 state; PLL_PD_CYCLES restarts from 0 after release.

Configuration
REQ-023 Macro SONIC_PMA_RESET_LOSS_CNT_EN defined SHALL add output lock_loss_cnt (8*NUM_LANES): per-lane 8-bit saturating count of RX_RDY->RX_LOCK transitions, cleared only by reset; undefined SHALL omit the port and counters, all other behaviour identical.

Verification
REQ-024 NUM_LANES=4, PLL_PD_CYCLES=10, TX_SETTLE_CYCLES=4, locks/cal ready from cycle 0 -> pll_powerdown drops after 10 clocks, tx_analogreset 1 clock later, tx_ready=4'hF 4 clocks after that.
REQ-025 rx_is_lockedtodata lane 2 toggles low once in RX_LOCK, RX_LOCK_CYCLES=8 -> rx_ready[2] rises exactly 8 clocks after last low; other lanes unaffected.
REQ-026 pll_locked[1] drops in TX_RDY -> next cycle tx_ready=0, pll_powerdown=4'hF, all rx_ready=0, rx_analogreset=4'hF.
REQ-027 Lane 0 loses data lock 3 times in RX_RDY with macro defined -> lock_loss_cnt[7:0]=3, 300 losses -> saturates at 255.
REQ-028 Reset asserted during TX_SETTLE -> next edge outputs equal REQ-021 values; sequence restarts with full PLL_PD_CYCLES.
